// File: rtl/cam_pkg.sv
// Shared constants, state encoding and helpers for the CAM match-vector reader.
package cam_pkg;

   localparam int CAM_DEPTH = 16;
   localparam int CAM_IDXW  = $clog2(CAM_DEPTH);
   localparam int CAM_CNTW  = $clog2(CAM_DEPTH + 1);

   // Widest match vector the popcount helper handles; narrower vectors are zero-extended.
   localparam int CAM_MAX_DEPTH = 256;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } cam_state_e;

   function automatic int popcount(input logic [CAM_MAX_DEPTH-1:0] vec);
      int cnt;
      cnt = 0;
      for (int i = 0; i < CAM_MAX_DEPTH; i++) begin
         cnt += int'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder: index of the lowest or highest set bit,
// plus any-bit-set and exactly-one-bit-set flags.
module cam_prio_enc #(
   parameter  int DEPTH     = 16,
   parameter  int LOW_FIRST = 1,
   localparam int IDXW      = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] vec,
   output logic [IDXW-1:0]  index,
   output logic             found,
   output logic             single
);

   generate
      if (LOW_FIRST != 0) begin : g_low
         // Walk downwards so the lowest set bit is the last assignment.
         always_comb begin
            index = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
               if (vec[i]) index = IDXW'(i);
            end
         end
      end else begin : g_high
         always_comb begin
            index = '0;
            for (int i = 0; i < DEPTH; i++) begin
               if (vec[i]) index = IDXW'(i);
            end
         end
      end
   endgenerate

   assign found  = |vec;
   assign single = found && ((vec & (vec - DEPTH'(1))) == '0);

endmodule

// File: rtl/cam_match_reader.sv
// Accepts one CAM match vector per search and emits the index of every set bit,
// one per valid/ready handshake, with miss, hit-count and last-index reporting.
module cam_match_reader
   import cam_pkg::*;
#(
   parameter  int DEPTH     = CAM_DEPTH,
   parameter  int LOW_FIRST = 1,
   localparam int IDXW      = $clog2(DEPTH),
   localparam int CNTW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] match_in,
   input  logic             match_valid,
   output logic             match_ready,
   input  logic             abort,
   output logic [IDXW-1:0]  idx_out,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic             idx_last,
   output logic [CNTW-1:0]  hit_count,
   output logic             miss,
   output logic             busy
);

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_SCAN = SCAN;

   logic [0:0]       state_reg;
   logic [DEPTH-1:0] pending_reg;
   logic [DEPTH-1:0] pending_next;
   logic             found;
   logic             single;
   logic             handshake;

   // idx_out depends only on the registered pending mask, never on match_in.
   cam_prio_enc #(
      .DEPTH     (DEPTH),
      .LOW_FIRST (LOW_FIRST)
   ) u_enc (
      .vec    (pending_reg),
      .index  (idx_out),
      .found  (found),
      .single (single)
   );

   assign busy         = (state_reg == ST_SCAN);
   assign match_ready  = (state_reg == ST_IDLE);
   assign idx_valid    = busy && found;
   assign idx_last     = idx_valid && single;
   assign handshake    = idx_valid && idx_ready;
   assign pending_next = pending_reg & ~(DEPTH'(1) << idx_out);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         pending_reg <= '0;
         hit_count   <= '0;
         miss        <= 1'b0;
      end else begin
         miss <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (match_valid) begin
                  pending_reg <= match_in;
                  hit_count   <= CNTW'(popcount(CAM_MAX_DEPTH'(match_in)));
                  if (match_in != '0) state_reg <= ST_SCAN;
                  else                miss      <= 1'b1;
               end
            end
            default: begin
               // Abort wins over a same-cycle handshake: nothing further is emitted.
               if (abort) begin
                  pending_reg <= '0;
                  state_reg   <= ST_IDLE;
               end else if (handshake) begin
                  pending_reg <= pending_next;
                  if (single) state_reg <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_match_reader.sv
// Directed bench for cam_match_reader: ascending and descending instances share
// stimulus; emitted indices are checked against scoreboard queues.
module tb_cam_match_reader;

   localparam int DEPTH = 16;
   localparam int IDXW  = $clog2(DEPTH);
   localparam int CNTW  = $clog2(DEPTH + 1);

   typedef struct {
      int idx;
      int last;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [DEPTH-1:0] match_in;
   logic             match_valid;
   logic             abort;
   logic             idx_ready;

   logic             lo_match_ready, hi_match_ready;
   logic [IDXW-1:0]  lo_idx_out, hi_idx_out;
   logic             lo_idx_valid, hi_idx_valid;
   logic             lo_idx_last, hi_idx_last;
   logic [CNTW-1:0]  lo_hit_count, hi_hit_count;
   logic             lo_miss, hi_miss;
   logic             lo_busy, hi_busy;

   int   vectors;
   int   miscompares;
   exp_t q_lo[$];
   exp_t q_hi[$];

   cam_match_reader #(.DEPTH(DEPTH), .LOW_FIRST(1)) u_low (
      .clk(clk), .rst(rst), .match_in(match_in), .match_valid(match_valid),
      .match_ready(lo_match_ready), .abort(abort), .idx_out(lo_idx_out),
      .idx_valid(lo_idx_valid), .idx_ready(idx_ready), .idx_last(lo_idx_last),
      .hit_count(lo_hit_count), .miss(lo_miss), .busy(lo_busy)
   );

   cam_match_reader #(.DEPTH(DEPTH), .LOW_FIRST(0)) u_high (
      .clk(clk), .rst(rst), .match_in(match_in), .match_valid(match_valid),
      .match_ready(hi_match_ready), .abort(abort), .idx_out(hi_idx_out),
      .idx_valid(hi_idx_valid), .idx_ready(idx_ready), .idx_last(hi_idx_last),
      .hit_count(hi_hit_count), .miss(hi_miss), .busy(hi_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected emission order for a vector, truncated to 'limit' handshakes.
   task automatic push_search(input logic [DEPTH-1:0] vec, input int limit);
      int   total;
      int   n;
      exp_t e;
      total = $countones(vec);
      n = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vec[i] && n < limit) begin
            e.idx  = i;
            e.last = (n == total - 1) ? 1 : 0;
            q_lo.push_back(e);
            n++;
         end
      end
      n = 0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec[i] && n < limit) begin
            e.idx  = i;
            e.last = (n == total - 1) ? 1 : 0;
            q_hi.push_back(e);
            n++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, {31'd0, lo_match_ready}, 32'd1);
      check({tag, "_valid"}, {31'd0, lo_idx_valid}, 32'd0);
      check({tag, "_last"},  {31'd0, lo_idx_last}, 32'd0);
      check({tag, "_miss"},  {31'd0, lo_miss}, 32'd0);
      check({tag, "_busy"},  {31'd0, lo_busy}, 32'd0);
      check({tag, "_idx"},   32'(lo_idx_out), 32'd0);
      check({tag, "_cnt"},   32'(lo_hit_count), 32'd0);
      check({tag, "_hi_valid"}, {31'd0, hi_idx_valid}, 32'd0);
      check({tag, "_hi_ready"}, {31'd0, hi_match_ready}, 32'd1);
   endtask

   // Scoreboard: every handshake about to happen at the next rising edge pops one entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (lo_idx_valid && idx_ready) begin
            if (q_lo.size() == 0) begin
               check("lo_unexpected_idx", 32'(lo_idx_out), 32'hFFFF_FFFF);
            end else begin
               e = q_lo.pop_front();
               check("lo_sb_idx", 32'(lo_idx_out), 32'(e.idx));
               check("lo_sb_last", {31'd0, lo_idx_last}, 32'(e.last));
            end
         end
         if (hi_idx_valid && idx_ready) begin
            if (q_hi.size() == 0) begin
               check("hi_unexpected_idx", 32'(hi_idx_out), 32'hFFFF_FFFF);
            end else begin
               e = q_hi.pop_front();
               check("hi_sb_idx", 32'(hi_idx_out), 32'(e.idx));
               check("hi_sb_last", {31'd0, hi_idx_last}, 32'(e.last));
            end
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      match_in    = '0;
      match_valid = 1'b0;
      abort       = 1'b0;
      idx_ready   = 1'b0;
      #1;
      check_reset("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single hit on entry 2 (search C3)
      match_in    = 16'h0004;
      match_valid = 1'b1;
      push_search(16'h0004, DEPTH);
      step();
      match_valid = 1'b0;
      check("t1_valid", {31'd0, lo_idx_valid}, 32'd1);
      check("t1_idx", 32'(lo_idx_out), 32'd2);
      check("t1_last", {31'd0, lo_idx_last}, 32'd1);
      check("t1_cnt", 32'(lo_hit_count), 32'd1);
      check("t1_ready", {31'd0, lo_match_ready}, 32'd0);
      check("t1_busy", {31'd0, lo_busy}, 32'd1);
      idx_ready = 1'b1;
      step();
      check("t1_done_valid", {31'd0, lo_idx_valid}, 32'd0);
      check("t1_done_ready", {31'd0, lo_match_ready}, 32'd1);

      // Three hits, continuous idx_ready
      match_in    = 16'h8005;
      match_valid = 1'b1;
      push_search(16'h8005, DEPTH);
      step();
      match_valid = 1'b0;
      check("t2_cnt", 32'(lo_hit_count), 32'd3);
      check("t2_lo_0", 32'(lo_idx_out), 32'd0);
      check("t2_hi_0", 32'(hi_idx_out), 32'd15);
      check("t2_lo_last0", {31'd0, lo_idx_last}, 32'd0);
      step();
      check("t2_lo_1", 32'(lo_idx_out), 32'd2);
      check("t2_hi_1", 32'(hi_idx_out), 32'd2);
      step();
      check("t2_lo_2", 32'(lo_idx_out), 32'd15);
      check("t2_lo_last2", {31'd0, lo_idx_last}, 32'd1);
      check("t2_hi_2", 32'(hi_idx_out), 32'd0);
      check("t2_hi_last2", {31'd0, hi_idx_last}, 32'd1);
      step();
      check("t2_done_valid", {31'd0, lo_idx_valid}, 32'd0);
      check("t2_done_ready", {31'd0, lo_match_ready}, 32'd1);

      // Miss (search AA)
      match_in    = 16'h0000;
      match_valid = 1'b1;
      step();
      match_valid = 1'b0;
      check("t3_miss", {31'd0, lo_miss}, 32'd1);
      check("t3_valid", {31'd0, lo_idx_valid}, 32'd0);
      check("t3_ready", {31'd0, lo_match_ready}, 32'd1);
      check("t3_cnt", 32'(lo_hit_count), 32'd0);
      step();
      check("t3_miss_pulse", {31'd0, lo_miss}, 32'd0);
      check("t3_valid2", {31'd0, lo_idx_valid}, 32'd0);

      // Backpressure for 3 cycles, ignored match_valid during scan
      idx_ready   = 1'b0;
      match_in    = 16'h0030;
      match_valid = 1'b1;
      push_search(16'h0030, DEPTH);
      step();
      check("t4_hold0_idx", 32'(lo_idx_out), 32'd4);
      check("t4_hold0_valid", {31'd0, lo_idx_valid}, 32'd1);
      check("t4_hi_first", 32'(hi_idx_out), 32'd5);
      match_in    = 16'hFFFF;
      match_valid = 1'b1;
      step();
      match_valid = 1'b0;
      check("t4_hold1_idx", 32'(lo_idx_out), 32'd4);
      check("t4_hold1_last", {31'd0, lo_idx_last}, 32'd0);
      check("t4_ignored_cnt", 32'(lo_hit_count), 32'd2);
      step();
      check("t4_hold2_idx", 32'(lo_idx_out), 32'd4);
      check("t4_hold2_valid", {31'd0, lo_idx_valid}, 32'd1);
      idx_ready = 1'b1;
      step();
      check("t4_next_idx", 32'(lo_idx_out), 32'd5);
      check("t4_next_last", {31'd0, lo_idx_last}, 32'd1);
      step();
      check("t4_done_valid", {31'd0, lo_idx_valid}, 32'd0);
      check("t4_done_ready", {31'd0, lo_match_ready}, 32'd1);
      check("t4_done_cnt", 32'(lo_hit_count), 32'd2);

      // All-hit vector, abort on the second handshake
      match_in    = 16'hFFFF;
      match_valid = 1'b1;
      push_search(16'hFFFF, 2);
      step();
      match_valid = 1'b0;
      check("t5_idx0", 32'(lo_idx_out), 32'd0);
      step();
      check("t5_idx1", 32'(lo_idx_out), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t5_abort_valid", {31'd0, lo_idx_valid}, 32'd0);
      check("t5_abort_ready", {31'd0, lo_match_ready}, 32'd1);
      check("t5_abort_busy", {31'd0, lo_busy}, 32'd0);
      check("t5_cnt", 32'(lo_hit_count), 32'd16);
      check("t5_hi_valid", {31'd0, hi_idx_valid}, 32'd0);
      step();
      check("t5_idle_valid", {31'd0, lo_idx_valid}, 32'd0);

      // Asynchronous reset mid-scan, then abort in IDLE alongside a new search
      idx_ready   = 1'b0;
      match_in    = 16'h00F0;
      match_valid = 1'b1;
      step();
      match_valid = 1'b0;
      check("t6_busy", {31'd0, lo_busy}, 32'd1);
      check("t6_idx", 32'(lo_idx_out), 32'd4);
      #2;
      rst = 1'b1;
      #1;
      check_reset("t6_async");
      @(posedge clk);
      #1;
      rst         = 1'b0;
      idx_ready   = 1'b1;
      abort       = 1'b1;
      match_in    = 16'h0001;
      match_valid = 1'b1;
      push_search(16'h0001, DEPTH);
      step();
      abort       = 1'b0;
      match_valid = 1'b0;
      check("t6_new_idx", 32'(lo_idx_out), 32'd0);
      check("t6_new_valid", {31'd0, lo_idx_valid}, 32'd1);
      check("t6_new_last", {31'd0, lo_idx_last}, 32'd1);
      step();
      check("t6_done_valid", {31'd0, lo_idx_valid}, 32'd0);
      step();
      check("sb_lo_drained", 32'(q_lo.size()), 32'd0);
      check("sb_hi_drained", 32'(q_hi.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cam_match_reader.md
Name: cam_match_reader

Overview:
- Consumer side of the CAM search interface.
- Accepts one DEPTH-bit match vector per search and walks it, emitting the encoded index of every set bit, one per handshake.
- Reports miss (no bit set), multi-hit count and last-index marking.
- Sits between the CAM match output and the lookup/action logic that needs addresses rather than a hit vector.

Parameters:
- DEPTH, 16, number of CAM entries (width of the match vector); must be ≥2.
- LOW_FIRST, 1, 1 = emit indices ascending from bit 0; 0 = descending from bit DEPTH-1.
- IDXW, $clog2(DEPTH), localparam, index width.
- CNTW, $clog2(DEPTH+1), localparam, hit-count width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- match_in  in  DEPTH  match vector from the CAM.
- match_valid  in  1  match_in is a completed search result.
- match_ready  out  1  block can accept a new search result.
- abort  in  1  synchronous: discard the remaining pending indices.
- idx_out  out  IDXW  encoded matching entry index.
- idx_valid  out  1  idx_out is valid.
- idx_ready  in  1  downstream accepts idx_out.
- idx_last  out  1  idx_out is the final index of this search.
- hit_count  out  CNTW  popcount of the accepted match vector; held until the next accept.
- miss  out  1  one-cycle pulse: the accepted vector was all zero.
- busy  out  1  a scan is in progress (state SCAN).

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - state = IDLE; pending mask = 0.
  - match_ready = 1.
  - idx_valid, idx_last, miss, busy = 0.
  - idx_out = 0; hit_count = 0.
- States: IDLE, SCAN.
- IDLE: match_ready = 1.
  - On match_valid in cycle N:
    - pending ← match_in; hit_count ← popcount(match_in).
    - If match_in ≠ 0: state → SCAN.
    - If match_in = 0: miss = 1 in cycle N+1 only; state stays IDLE; match_ready stays 1.
- SCAN: match_ready = 0; busy = 1.
  - match_valid is ignored (no capture, no side effect).
  - idx_valid = 1 from cycle N+1.
  - idx_out = priority encode of pending: lowest set bit if LOW_FIRST = 1, highest set bit otherwise.
  - idx_out is a function of registered pending only; there is no combinational path from match_in to idx_out.
  - idx_last = 1 when exactly one bit of pending is set.
- Handshake (idx_valid & idx_ready):
  - Clear the emitted bit in pending.
  - If that was the last bit: state → IDLE; idx_valid = 0 and match_ready = 1 in the next cycle.
  - Otherwise the next index is presented in the next cycle.
  - Throughput: one index per cycle under continuous idx_ready.
- Backpressure: while idx_valid & !idx_ready, idx_out, idx_last and idx_valid hold stable.
- abort in SCAN: pending ← 0; state → IDLE.
  - abort wins over a simultaneous idx handshake; the handshake is treated as completed but no further index follows.
  - abort in IDLE has no effect and does not block a same-cycle match_valid capture.
- No state spans searches: a new search always restarts from pending = match_in.
- Latency from the match_valid accept to the first idx_valid is exactly 1 cycle.
- A search that hits all DEPTH bits produces DEPTH handshakes; hit_count = DEPTH, which fits CNTW.

Decomposition:
- Shared package cam_pkg:
  - CAM_DEPTH default.
  - CAM_IDXW and CAM_CNTW constants.
  - State enum {IDLE, SCAN}.
- Sub-module cam_prio_enc (combinational):
  - Inputs: vector[DEPTH], direction parameter.
  - Outputs: index[IDXW], found, single (exactly one bit set).
  - Instantiated once on the pending register.
- popcount is a function in cam_pkg.

Test Plan:
- CAM loaded with 3F, 7A, C3, 4B at entries 0–3; search C3 → match_in = 16'h0004 accepted.
  - Next cycle: idx_out = 2, idx_last = 1, hit_count = 1.
  - With idx_ready = 1: idx_valid drops the following cycle; match_ready returns to 1.
- match_in = 16'h8005, LOW_FIRST = 1, idx_ready held at 1:
  - idx_out sequence 0, 2, 15 on consecutive cycles; idx_last only on 15; hit_count = 3.
  - Repeat with LOW_FIRST = 0: sequence 15, 2, 0.
- Search AA (no stored entry) → match_in = 0:
  - miss high for exactly one cycle; idx_valid never asserts; match_ready stays 1.
- match_in = 16'h0030 with idx_ready low for 3 cycles:
  - idx_out = 4 held stable with idx_valid = 1.
  - Then 4 and 5 are accepted.
  - A match_valid pulse during the scan is ignored.
- match_in = 16'hFFFF, then abort asserted together with the 2nd handshake:
  - Exactly 2 indices (0, 1) are emitted; IDLE next cycle; hit_count = 16.
- rst asserted asynchronously mid-scan of 16'h00F0:
  - All outputs return to reset values immediately.
  - After release, a new search 16'h0001 yields idx_out = 0.
